// File: rtl/apb_master_mslv.sv
// APB master with multi-slave address decode, PREADY watchdog and a single-cycle
// response pulse per accepted command.
module apb_master_mslv #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AW-1:0]       cmd_addr,
  input  logic [DW-1:0]       cmd_wdata,
  input  logic [DW/8-1:0]     cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  output logic [DW-1:0]       rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [NSLV-1:0]     PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [AW-1:0]       PADDR,
  output logic [DW-1:0]       PWDATA,
  output logic [DW/8-1:0]     PSTRB,
  output logic [2:0]          PPROT,
  input  logic [NSLV-1:0]     PREADY,
  input  logic [NSLV*DW-1:0]  PRDATA,
  input  logic [NSLV-1:0]     PSLVERR
);
  localparam int IDXW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt;
  logic            derr_pend;
  logic            addr_ok, sel_ready, sel_err, wdog, done, accept;
  logic [DW-1:0]   sel_rdata;

  always_comb begin
    idx_d = '0;
    if (NSLV > 1) idx_d = cmd_addr[AW-1 -: IDXW];
  end

  assign addr_ok   = ({1'b0, idx_d} < (IDXW+1)'(NSLV));
  assign sel_ready = PREADY[idx_q];
  assign sel_err   = PSLVERR[idx_q];
  assign sel_rdata = PRDATA[idx_q*DW +: DW];
  assign wdog      = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT-1)) && !sel_ready;
  assign done      = (state == ACCESS) && (sel_ready || wdog);
  assign cmd_ready = (state == IDLE) || done;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && addr_ok) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = (accept && addr_ok) ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= '0;
      PPROT       <= '0;
      idx_q       <= '0;
      cnt         <= '0;
      derr_pend   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      if (state == SETUP) PENABLE <= 1'b1;
      if (state == ACCESS && !done) cnt <= cnt + 1'b1;
      // A decode error accepted alongside a completion would collide in the
      // response slot, so it is parked for one cycle in derr_pend.
      if (done) begin
        PSEL        <= '0;
        PENABLE     <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_err     <= sel_ready ? sel_err : 1'b1;
        rsp_timeout <= wdog;
        rsp_rdata   <= (!PWRITE && sel_ready && !sel_err) ? sel_rdata : '0;
        derr_pend   <= accept && !addr_ok;
      end else if (derr_pend || (accept && !addr_ok)) begin
        rsp_valid   <= 1'b1;
        rsp_err     <= 1'b1;
        derr_pend   <= derr_pend && accept && !addr_ok;
      end
      if (accept && addr_ok) begin
        PADDR       <= cmd_addr;
        PWRITE      <= cmd_write;
        PWDATA      <= cmd_wdata;
        PPROT       <= cmd_prot;
        PSTRB       <= cmd_write ? cmd_strb : '0;
        idx_q       <= idx_d;
        PSEL        <= '0;
        PSEL[idx_d] <= 1'b1;
        PENABLE     <= 1'b0;
        cnt         <= '0;
      end
    end
  end
endmodule

// File: tb/tb_apb_master_mslv.sv
// Bench for apb_master_mslv: a 4-slave/TIMEOUT=4 instance checked through a
// response scoreboard, plus a 3-slave instance for the decode-error path.
module tb_apb_master_mslv;
  logic        PCLK = 1'b0;
  logic        PRESET;
  always #5 PCLK = ~PCLK;

  logic        cmd_valid, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, PENABLE, PWRITE;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  logic [3:0]  PSEL, PSTRB, PREADY, PSLVERR;
  logic [2:0]  PPROT;
  logic [127:0] PRDATA;

  logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_err3, rsp_timeout3;
  logic        PENABLE3, PWRITE3;
  logic [31:0] rsp_rdata3, PADDR3, PWDATA3;
  logic [2:0]  PSEL3, PREADY3, PSLVERR3, PPROT3;
  logic [3:0]  PSTRB3;
  logic [95:0] PRDATA3;

  apb_master_mslv #(.AW(32), .DW(32), .NSLV(4), .TIMEOUT(4)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  apb_master_mslv #(.AW(32), .DW(32), .NSLV(3), .TIMEOUT(16)) u_dut3 (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .rsp_timeout(rsp_timeout3),
    .PSEL(PSEL3), .PENABLE(PENABLE3), .PWRITE(PWRITE3), .PADDR(PADDR3), .PWDATA(PWDATA3),
    .PSTRB(PSTRB3), .PPROT(PPROT3), .PREADY(PREADY3), .PRDATA(PRDATA3), .PSLVERR(PSLVERR3)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   fails  = 0;

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge PCLK) begin
    if (rsp_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        fails++; $display("FAIL rsp_unexpected: got rsp_valid=1, want no response");
      end else begin
        mon_e = sbq.pop_front();
        if ({rsp_rdata, rsp_err, rsp_timeout} !== {mon_e.rdata, mon_e.err, mon_e.to}) begin
          fails++;
          $display("FAIL rsp_fields: got rdata=%h err=%b to=%b want rdata=%h err=%b to=%b",
                   rsp_rdata, rsp_err, rsp_timeout, mon_e.rdata, mon_e.err, mon_e.to);
        end
      end
    end
  end

  task automatic step();
    @(negedge PCLK);
  endtask

  task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input logic [2:0] prot);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = wd; cmd_strb = strb; cmd_prot = prot;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) step();
    checks++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT} !== '0) begin
      fails++; $display("FAIL reset_apb: got psel=%b pen=%b paddr=%h pwdata=%h pstrb=%h",
                        PSEL, PENABLE, PADDR, PWDATA, PSTRB); end
    checks++; if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
      fails++; $display("FAIL reset_rsp: got v=%b rdata=%h err=%b to=%b, want all 0",
                        rsp_valid, rsp_rdata, rsp_err, rsp_timeout); end
    PRESET = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    PREADY = 4'b0010; PSLVERR = 4'b0000;
    PRDATA = {$urandom, $urandom, $urandom, $urandom};
    drive_cmd(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010);
    sbq.push_back('{32'h0, 1'b0, 1'b0});
    step();
    cmd_valid = 1'b0;
    checks++; if ({PSEL, PENABLE} !== {4'b0010, 1'b0}) begin
      fails++; $display("FAIL wr_setup: got psel=%b pen=%b want 0010/0", PSEL, PENABLE); end
    checks++; if ({PADDR, PWDATA, PSTRB, PWRITE, PPROT} !== {32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 3'b010}) begin
      fails++; $display("FAIL wr_fields: got paddr=%h pwdata=%h pstrb=%h pwrite=%b pprot=%b",
                        PADDR, PWDATA, PSTRB, PWRITE, PPROT); end
    step();
    checks++; if ({PSEL, PENABLE} !== {4'b0010, 1'b1}) begin
      fails++; $display("FAIL wr_access: got psel=%b pen=%b want 0010/1", PSEL, PENABLE); end
    step();
    checks++; if ({PSEL, PENABLE, rsp_valid} !== {4'b0000, 1'b0, 1'b1}) begin
      fails++; $display("FAIL wr_done: got psel=%b pen=%b rsp_valid=%b want 0000/0/1",
                        PSEL, PENABLE, rsp_valid); end
    step();
    PREADY = 4'b0000;
  endtask

  task automatic test_read_wait();
    PREADY = 4'b0000; PSLVERR = 4'b0000;
    PRDATA = {32'h1234_5678, $urandom, $urandom, $urandom};
    drive_cmd(1'b0, 32'hC000_0004, 32'h1111_2222, 4'hF, 3'b000);
    sbq.push_back('{32'h1234_5678, 1'b0, 1'b0});
    step();
    cmd_valid = 1'b0;
    checks++; if ({PSEL, PENABLE, PSTRB, PWRITE} !== {4'b1000, 1'b0, 4'h0, 1'b0}) begin
      fails++; $display("FAIL rd_setup: got psel=%b pen=%b pstrb=%h pwrite=%b want 1000/0/0/0",
                        PSEL, PENABLE, PSTRB, PWRITE); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) PREADY = 4'b1000;
      checks++; if ({PSEL, PENABLE} !== {4'b1000, 1'b1}) begin
        fails++; $display("FAIL rd_access%0d: got psel=%b pen=%b want 1000/1", i, PSEL, PENABLE); end
    end
    step();
    checks++; if ({PSEL, PENABLE, rsp_valid} !== {4'b0000, 1'b0, 1'b1}) begin
      fails++; $display("FAIL rd_done: got psel=%b pen=%b rsp_valid=%b want 0000/0/1",
                        PSEL, PENABLE, rsp_valid); end
    PREADY = 4'b0000;
    step();
  endtask

  task automatic test_back_to_back();
    PREADY = 4'b1111; PSLVERR = 4'b0000;
    drive_cmd(1'b1, 32'h0000_0020, 32'hA5A5_0001, 4'h3, 3'b001);
    sbq.push_back('{32'h0, 1'b0, 1'b0});
    step();
    checks++; if ({PSEL, PENABLE, PADDR} !== {4'b0001, 1'b0, 32'h0000_0020}) begin
      fails++; $display("FAIL b2b_setup1: got psel=%b pen=%b paddr=%h", PSEL, PENABLE, PADDR); end
    drive_cmd(1'b1, 32'h8000_0040, 32'h5A5A_0002, 4'hC, 3'b100);
    sbq.push_back('{32'h0, 1'b0, 1'b0});
    step();
    checks++; if ({PSEL, PENABLE, cmd_ready} !== {4'b0001, 1'b1, 1'b1}) begin
      fails++; $display("FAIL b2b_access1: got psel=%b pen=%b ready=%b want 0001/1/1",
                        PSEL, PENABLE, cmd_ready); end
    step();
    cmd_valid = 1'b0;
    checks++; if ({PSEL, PENABLE, PADDR, PWDATA, PSTRB, rsp_valid} !==
                  {4'b0100, 1'b0, 32'h8000_0040, 32'h5A5A_0002, 4'hC, 1'b1}) begin
      fails++; $display("FAIL b2b_setup2: got psel=%b pen=%b paddr=%h pwdata=%h pstrb=%h rsp=%b",
                        PSEL, PENABLE, PADDR, PWDATA, PSTRB, rsp_valid); end
    step();
    checks++; if ({PSEL, PENABLE, rsp_valid} !== {4'b0100, 1'b1, 1'b0}) begin
      fails++; $display("FAIL b2b_access2: got psel=%b pen=%b rsp=%b want 0100/1/0",
                        PSEL, PENABLE, rsp_valid); end
    step();
    checks++; if ({PSEL, rsp_valid} !== {4'b0000, 1'b1}) begin
      fails++; $display("FAIL b2b_done: got psel=%b rsp=%b want 0000/1", PSEL, rsp_valid); end
    PREADY = 4'b0000;
    step();
  endtask

  task automatic test_timeout();
    int n = 0;
    PREADY = 4'b0000; PSLVERR = 4'b0001;
    PRDATA = {$urandom, $urandom, $urandom, $urandom};
    drive_cmd(1'b0, 32'h0000_0100, 32'h0, 4'hF, 3'b000);
    sbq.push_back('{32'h0, 1'b1, 1'b1});
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (PENABLE === 1'b1 && PSEL === 4'b0001) n++;
      else break;
    end
    checks++; if (n != 4) begin
      fails++; $display("FAIL to_cycles: got %0d access cycles want 4", n); end
    checks++; if ({PSEL, PENABLE, rsp_valid} !== {4'b0000, 1'b0, 1'b1}) begin
      fails++; $display("FAIL to_abort: got psel=%b pen=%b rsp=%b want 0000/0/1",
                        PSEL, PENABLE, rsp_valid); end
    PREADY = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({rsp_valid, PSEL} !== 5'b0) begin
        fails++; $display("FAIL to_late_ready: got rsp=%b psel=%b want 0/0000", rsp_valid, PSEL); end
    end
    PREADY = 4'b0000; PSLVERR = 4'b0000;
  endtask

  task automatic test_slverr();
    PREADY = 4'b0100; PSLVERR = 4'b0100;
    PRDATA = {32'h0, 32'hAAAA_5555, 32'h0, 32'h0};
    drive_cmd(1'b0, 32'h8000_0008, 32'h0, 4'hF, 3'b000);
    sbq.push_back('{32'h0, 1'b1, 1'b0});
    step();
    cmd_valid = 1'b0;
    repeat (2) step();
    checks++; if (rsp_valid !== 1'b1) begin
      fails++; $display("FAIL slverr_rsp: got rsp_valid=%b want 1", rsp_valid); end
    PREADY = 4'b0000; PSLVERR = 4'b0000;
    step();
  endtask

  task automatic test_decode_err();
    PREADY3 = 3'b111; PSLVERR3 = 3'b000; PRDATA3 = {$urandom, $urandom, $urandom};
    cmd_write = 1'b0; cmd_addr = 32'hC000_0000; cmd_valid3 = 1'b1;
    #1;
    checks++; if (cmd_ready3 !== 1'b1) begin
      fails++; $display("FAIL derr_ready: got %b want 1", cmd_ready3); end
    step();
    cmd_valid3 = 1'b0;
    checks++; if ({PSEL3, PENABLE3} !== 4'b0) begin
      fails++; $display("FAIL derr_psel: got psel=%b pen=%b want 000/0", PSEL3, PENABLE3); end
    checks++; if ({rsp_valid3, rsp_err3, rsp_timeout3, rsp_rdata3} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      fails++; $display("FAIL derr_rsp: got v=%b err=%b to=%b rdata=%h want 1/1/0/0",
                        rsp_valid3, rsp_err3, rsp_timeout3, rsp_rdata3); end
    step();
    checks++; if ({rsp_valid3, PSEL3} !== 4'b0) begin
      fails++; $display("FAIL derr_once: got rsp=%b psel=%b want 0/000", rsp_valid3, PSEL3); end
  endtask

  task automatic test_reset_mid();
    PREADY = 4'b0000;
    drive_cmd(1'b0, 32'h4000_0000, 32'h0, 4'hF, 3'b000);
    step();
    cmd_valid = 1'b0;
    step();
    checks++; if ({PSEL, PENABLE} !== {4'b0010, 1'b1}) begin
      fails++; $display("FAIL rst_mid_access: got psel=%b pen=%b want 0010/1", PSEL, PENABLE); end
    PRESET = 1'b1;
    step();
    checks++; if ({PSEL, PENABLE, rsp_valid} !== 6'b0) begin
      fails++; $display("FAIL rst_mid_abort: got psel=%b pen=%b rsp=%b want 0", PSEL, PENABLE, rsp_valid); end
    PRESET = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_ready: got %b want 1", cmd_ready); end
    PREADY = 4'b0010;
    repeat (3) step();
    checks++; if ({rsp_valid, PSEL} !== 5'b0) begin
      fails++; $display("FAIL rst_mid_quiet: got rsp=%b psel=%b want 0", rsp_valid, PSEL); end
    PREADY = 4'b0000;
  endtask

  initial begin
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_valid3 = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    PREADY = '0; PSLVERR = '0; PRDATA = '0;
    PREADY3 = '0; PSLVERR3 = '0; PRDATA3 = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_decode_err();
    test_reset_mid();
    repeat (3) step();
    checks++; if (sbq.size() != 0) begin
      fails++; $display("FAIL sb_drain: got %0d pending responses want 0", sbq.size()); end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/apb_master_mslv.md
Name: apb_master_mslv

Overview:
- Parametrised APB master that turns a valid/ready command interface into APB transfers.
- Decodes the target slave from the upper address bits and drives one of NSLV PSEL lines.
- Muxes the selected slave's PREADY/PRDATA/PSLVERR back into a one-cycle response pulse.
- Adds PSTRB/PPROT, back-to-back transfers, an address-decode error path and a PREADY watchdog.

Parameters:
- AW, 32, address width.
- DW, 32, data width; multiple of 8.
- NSLV, 4, number of slaves, 1..16. IDXW = (NSLV>1) ? $clog2(NSLV) : 1.
- TIMEOUT, 16, maximum consecutive ACCESS cycles with PREADY low before abort; 0 disables the watchdog.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  byte address.
- cmd_wdata  in  DW  write data.
- cmd_strb  in  DW/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DW  read data; 0 for writes and errors.
- rsp_err  out  1  slave error, decode error or timeout.
- rsp_timeout  out  1  the error was caused by the watchdog.
- PSEL  out  NSLV  one-hot slave select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PADDR  out  AW  APB address.
- PWDATA  out  DW  APB write data.
- PSTRB  out  DW/8  APB strobes.
- PPROT  out  3  APB protection.
- PREADY  in  NSLV  per-slave ready.
- PRDATA  in  NSLV*DW  per-slave read data; slave i occupies [i*DW +: DW].
- PSLVERR  in  NSLV  per-slave error.

Behaviour:
- Reset (PRESET=1 at a PCLK edge) sets all of the following to 0: state=IDLE, PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, timeout counter.
- Reset mid-transfer aborts the transfer with no response; PSEL and PENABLE are low after that edge.
- All outputs are registered except cmd_ready, which is combinational.
- cmd_ready = (state==IDLE) | (state==ACCESS & done).
- done = PREADY[idx] | wdog; wdog = (TIMEOUT!=0) & (cnt==TIMEOUT-1) & ~PREADY[idx].
- Decode: idx = cmd_addr[AW-1 -: IDXW], or idx=0 when NSLV=1. The address is invalid if idx >= NSLV.
- On accept with a valid address:
  - Register PADDR, PWRITE, PWDATA, PPROT and idx.
  - PSTRB = cmd_strb for writes, 0 for reads.
  - PSEL[idx]=1, PENABLE=0, next state SETUP.
- On accept with an invalid address:
  - No PSEL is asserted and state stays/returns to IDLE.
  - Next cycle: rsp_valid=1, rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- SETUP lasts exactly one cycle, then ACCESS: PENABLE=1, PSEL held.
- ACCESS is held while ~done; cnt increments each ACCESS cycle and clears on entry to SETUP.
- On done:
  - Next cycle rsp_valid=1.
  - rsp_err = PREADY[idx] ? PSLVERR[idx] : 1.
  - rsp_timeout = wdog.
  - rsp_rdata = PRDATA slice idx for reads without error, else 0.
  - If cmd_valid is high in the same cycle, the new command is accepted and the next state is SETUP directly (back-to-back, PSEL re-driven for the new idx, PENABLE=0). Otherwise next state is IDLE with PSEL=0, PENABLE=0.
- PSLVERR[idx] is sampled only when PREADY[idx]=1 in ACCESS.
- PADDR, PWRITE, PWDATA, PSTRB and PPROT are held stable from SETUP through the last ACCESS cycle. They keep their last values in IDLE.
- rsp_valid is high for exactly one cycle per accepted command. There is no backpressure on rsp; the consumer must take it.
- Non-selected PREADY, PRDATA and PSLVERR inputs are ignored.
- Watchdog abort: PSEL and PENABLE drop on the following edge. A PREADY arriving later from that slave is ignored.

Test Plan:
- Write, NSLV=4, cmd_addr=0x4000_0010, wdata=0xDEADBEEF, strb=4'hF, PREADY[1]=1 immediately:
  - PSEL=4'b0010 SETUP 1 cycle, ACCESS 1 cycle, PSTRB=F.
  - rsp_valid one cycle later with err=0, rdata=0.
- Read from addr 0xC000_0004, PREADY[3] low 2 ACCESS cycles then high, PRDATA slice3=0x1234_5678:
  - ACCESS lasts 3 cycles, PSTRB=0.
  - rsp_rdata=0x12345678, err=0.
- Two writes with cmd_valid held continuously, zero-wait slave:
  - Sequence SETUP, ACCESS, SETUP, ACCESS with no IDLE cycle.
  - Two rsp_valid pulses, 2 cycles apart.
- TIMEOUT=4, slave 0 never ready:
  - Exactly 4 ACCESS cycles, then PSEL=0.
  - rsp_err=1, rsp_timeout=1, rdata=0.
  - Late PREADY[0] produces no extra response.
- NSLV=3, addr 0xC000_0000 (idx=3):
  - No PSEL asserted.
  - rsp_valid next cycle with err=1, timeout=0.
- PSLVERR[2]=1 with PREADY[2]=1 on a read: rsp_err=1, rsp_rdata=0.
- PRESET asserted during ACCESS: PSEL=0, PENABLE=0 after the edge, no rsp_valid, cmd_ready=1 after reset release.
